// File: rtl/dmux8way16_dispatch_pkg.sv
// Shared constants and types for the 8-way 16-bit write dispatcher.
// Channel indices match the in_sel encoding (0=a .. 7=h).
package dmux8way16_dispatch_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int WORD_W = 16;

    localparam logic [SEL_W-1:0] CH_A = 3'd0;
    localparam logic [SEL_W-1:0] CH_B = 3'd1;
    localparam logic [SEL_W-1:0] CH_C = 3'd2;
    localparam logic [SEL_W-1:0] CH_D = 3'd3;
    localparam logic [SEL_W-1:0] CH_E = 3'd4;
    localparam logic [SEL_W-1:0] CH_F = 3'd5;
    localparam logic [SEL_W-1:0] CH_G = 3'd6;
    localparam logic [SEL_W-1:0] CH_H = 3'd7;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] result;
        result      = '0;
        result[sel] = 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/dmux8way16_dispatch_slot.sv
// One-entry holding register with valid/ready handshake.
// A load on the same edge as a drain overwrites the word and keeps the slot full.
module dispatch_slot
    import dmux8way16_dispatch_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             can_load
);

    slot_state_t state;
    slot_state_t state_next;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: begin
                if (load) begin
                    state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (drain_ready && !load) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    // Data is kept after a drain; only the valid flag marks it as fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= load_data;
        end
    end

    assign data     = data_reg;
    assign valid    = (state == SLOT_FULL);
    assign can_load = (state == SLOT_EMPTY) || drain_ready;

endmodule

// File: rtl/dmux8way16_dispatch.sv
// Routes one input word to one of eight buffered output channels by in_sel.
// Each channel stalls independently; accepted_cnt counts accepted words.
module dmux8way16_dispatch
    import dmux8way16_dispatch_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [WIDTH-1:0]  out_c,
    output logic [WIDTH-1:0]  out_d,
    output logic [WIDTH-1:0]  out_e,
    output logic [WIDTH-1:0]  out_f,
    output logic [WIDTH-1:0]  out_g,
    output logic [WIDTH-1:0]  out_h,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [CNT_W-1:0]  accepted_cnt
);

    logic [NUM_CH-1:0] sel_hot;
    logic [NUM_CH-1:0] slot_load;
    logic [NUM_CH-1:0] slot_can_load;
    logic [NUM_CH-1:0] slot_valid;
    logic [WIDTH-1:0]  slot_data [NUM_CH];
    logic              accept;
    logic [CNT_W-1:0]  cnt_reg;

    // in_ready depends only on the addressed slot, never on in_valid.
    assign sel_hot   = sel_onehot(in_sel);
    assign in_ready  = slot_can_load[in_sel];
    assign accept    = in_valid && in_ready;
    assign slot_load = sel_hot & {NUM_CH{accept}};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        dispatch_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .load        (slot_load[k]),
            .load_data   (in_data),
            .drain_ready (out_ready[k]),
            .data        (slot_data[k]),
            .valid       (slot_valid[k]),
            .can_load    (slot_can_load[k])
        );
    end

    // Counter wraps silently at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign accepted_cnt = cnt_reg;
    assign out_valid    = slot_valid;
    assign out_a        = slot_data[CH_A];
    assign out_b        = slot_data[CH_B];
    assign out_c        = slot_data[CH_C];
    assign out_d        = slot_data[CH_D];
    assign out_e        = slot_data[CH_E];
    assign out_f        = slot_data[CH_F];
    assign out_g        = slot_data[CH_G];
    assign out_h        = slot_data[CH_H];

endmodule

// File: tb/tb_dmux8way16_dispatch.sv
// Scoreboard bench for dmux8way16_dispatch: accepted words are queued at
// drive time and popped when they appear on their channel one cycle later.
module tb_dmux8way16_dispatch;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [15:0] accepted_cnt;

    logic [15:0] out_ch [8];

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] data;
    } sb_item_t;

    sb_item_t    sb_q [$];
    logic [15:0] exp_data [8];
    logic [7:0]  exp_valid;
    logic [15:0] exp_cnt;
    int          vectors;
    int          miscompares;

    dmux8way16_dispatch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_sel       (in_sel),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_c        (out_c),
        .out_d        (out_d),
        .out_e        (out_e),
        .out_f        (out_f),
        .out_g        (out_g),
        .out_h        (out_h),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .accepted_cnt (accepted_cnt)
    );

    assign out_ch[0] = out_a;
    assign out_ch[1] = out_b;
    assign out_ch[2] = out_c;
    assign out_ch[3] = out_d;
    assign out_ch[4] = out_e;
    assign out_ch[5] = out_f;
    assign out_ch[6] = out_g;
    assign out_ch[7] = out_h;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_model();
        for (int k = 0; k < 8; k++) exp_data[k] = 16'h0000;
        exp_valid = 8'h00;
        exp_cnt   = 16'h0000;
        sb_q.delete();
    endtask

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic drive_cycle(input logic v, input logic [2:0] sel, input logic [15:0] d,
                               input logic [7:0] rdy, input bit full_check);
        logic     exp_rdy;
        logic     acc;
        sb_item_t it;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = rdy;
        #1;
        exp_rdy = !exp_valid[sel] || rdy[sel];
        if (full_check) begin
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++;
                $display("[TB] FAIL in_ready sel=%0d got=%b want=%b", sel, in_ready, exp_rdy);
            end
        end
        acc = v && exp_rdy;
        for (int k = 0; k < 8; k++) begin
            if (exp_valid[k] && rdy[k]) exp_valid[k] = 1'b0;
        end
        if (acc) begin
            exp_data[sel]  = d;
            exp_valid[sel] = 1'b1;
            exp_cnt        = exp_cnt + 16'd1;
            sb_q.push_back('{ch: sel, data: d});
        end
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            vectors++;
            if (out_ch[it.ch] !== it.data || out_valid[it.ch] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL delivered ch=%0d got=%h/v%b want=%h/v1",
                         it.ch, out_ch[it.ch], out_valid[it.ch], it.data);
            end
        end
        if (full_check) begin
            vectors++;
            if (out_valid !== exp_valid || accepted_cnt !== exp_cnt) begin
                miscompares++;
                $display("[TB] FAIL status got valid=%h cnt=%h want valid=%h cnt=%h",
                         out_valid, accepted_cnt, exp_valid, exp_cnt);
            end
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (out_ch[k] !== exp_data[k]) begin
                    miscompares++;
                    $display("[TB] FAIL data ch=%0d got=%h want=%h", k, out_ch[k], exp_data[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_data   = 16'h0000;
        out_ready = 8'h00;
        clear_model();
        #2;
        vectors++;
        if (out_valid !== 8'h00 || accepted_cnt !== 16'h0000 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_status got valid=%h cnt=%h rdy=%b want 00/0000/1",
                     out_valid, accepted_cnt, in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (out_ch[k] !== 16'h0000) begin
                miscompares++;
                $display("[TB] FAIL reset_data ch=%0d got=%h want=0000", k, out_ch[k]);
            end
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        drive_cycle(1'b1, 3'd3, 16'hBEEF, 8'h00, 1'b1);
        vectors++;
        if (out_d !== 16'hBEEF || out_valid !== 8'h08 || accepted_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL single got d=%h valid=%h cnt=%h want BEEF/08/0001",
                     out_d, out_valid, accepted_cnt);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 3'd3, 16'h1234, 8'h00, 1'b1);
        vectors++;
        if (out_d !== 16'hBEEF || accepted_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL stall_hold got d=%h cnt=%h want BEEF/0001", out_d, accepted_cnt);
        end
        drive_cycle(1'b1, 3'd3, 16'h1234, 8'h08, 1'b1);
        vectors++;
        if (out_d !== 16'h1234 || out_valid[3] !== 1'b1 || accepted_cnt !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL stall_release got d=%h v=%b cnt=%h want 1234/1/0002",
                     out_d, out_valid[3], accepted_cnt);
        end
        drive_cycle(1'b0, 3'd0, 16'h0000, 8'hFF, 1'b1);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input bit check);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        clear_model();
        if (check) begin
            vectors++;
            if (out_valid !== 8'h00 || accepted_cnt !== 16'h0000) begin
                miscompares++;
                $display("[TB] FAIL async_reset got valid=%h cnt=%h want 00/0000",
                         out_valid, accepted_cnt);
            end
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (out_ch[k] !== 16'h0000) begin
                    miscompares++;
                    $display("[TB] FAIL async_reset_data ch=%0d got=%h want=0000", k, out_ch[k]);
                end
            end
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        async_reset(1'b0);
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 3'(i), 16'(i), 8'hFF, 1'b1);
        vectors++;
        if (accepted_cnt !== 16'd8) begin
            miscompares++;
            $display("[TB] FAIL b2b_cnt got=%h want=0008", accepted_cnt);
        end
        drive_cycle(1'b0, 3'd0, 16'h0000, 8'hFF, 1'b1);
    endtask

    task automatic test_independent();
        drive_cycle(1'b1, 3'd0, 16'h0A0A, 8'h00, 1'b1);
        drive_cycle(1'b1, 3'd0, 16'hDEAD, 8'h00, 1'b1);
        drive_cycle(1'b1, 3'd5, 16'hA5A5, 8'h00, 1'b1);
        vectors++;
        if (out_f !== 16'hA5A5 || out_a !== 16'h0A0A || out_valid[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL independent got f=%h a=%h va=%b want A5A5/0A0A/1",
                     out_f, out_a, out_valid[0]);
        end
        drive_cycle(1'b0, 3'd0, 16'h0000, 8'hFF, 1'b1);
    endtask

    task automatic test_wrap();
        async_reset(1'b0);
        for (int i = 0; i < 65535; i++) drive_cycle(1'b1, 3'(i), 16'(i), 8'hFF, 1'b0);
        vectors++;
        if (accepted_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL wrap_pre got=%h want=FFFF", accepted_cnt);
        end
        drive_cycle(1'b1, 3'd2, 16'hC0DE, 8'hFF, 1'b1);
        vectors++;
        if (accepted_cnt !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL wrap got=%h want=0000", accepted_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 3'(i), 16'h5000 + 16'(i), 8'h00, 1'b1);
        vectors++;
        if (out_valid !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL prefill got=%h want=FF", out_valid);
        end
        async_reset(1'b1);
        test_single();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_independent();
        test_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
